// File: rtl/mont_mul_ctrl_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier controller.
//   N     : operand / modulus width
//   W     : adder operand width (N+3), fixed by the multi-precision adder
//   IW    : width of the bit-iteration counter
//   state_e  : controller FSM states (4-bit encoding)
//   add_op_e : adder operation code driven on add_subtract
package mont_mul_ctrl_pkg;

  localparam int N  = 1024;
  localparam int W  = N + 3;
  localparam int IW = $clog2(N);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_TB,
    S_ADD_B,
    S_WB,
    S_TM,
    S_ADD_M,
    S_WM,
    S_SHR,
    S_FS,
    S_WS,
    S_FIN
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

endpackage : mont_mul_ctrl_pkg

// File: rtl/mont_mul_ctrl.sv
// Radix-2 Montgomery multiplier controller: result = a*b*2^-N mod M.
// Drives an external W-bit adder/subtractor through a start/done handshake.
// Per bit of a it performs a conditional C+B, a conditional C+M and a right
// shift; it finishes with one conditional final subtraction C-M.
//
// Ports
//   clk, resetn       clock, synchronous active-low reset
//   start             1-cycle pulse, samples in_a/in_b/in_m when idle
//   in_a, in_b, in_m  multiplier, multiplicand (both < M), odd modulus
//   result            a*b*2^-N mod M, valid from done until the next start
//   done              1-cycle pulse when result is valid
//   busy              high from the start-accept edge until the done cycle
//   add_start         1-cycle request to the adder
//   add_subtract      0 = add, 1 = subtract
//   add_a, add_b      adder operands (C, and zero-extended B or M)
//   add_result        W+1-bit adder output (bit W = carry / no-borrow)
//   add_done          1-cycle adder completion pulse
module mont_mul_ctrl
  import mont_mul_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_result,
  input  logic         add_done
);

  state_e        state_q, state_d;
  logic [W-1:0]  c_q, c_d;
  logic [IW-1:0] i_q, i_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  m_q, m_d;
  add_op_e       op;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    i_d      = i_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          c_d     = '0;
          i_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_TB;
      S_TB:    state_d = a_q[i_q] ? S_ADD_B : S_TM;
      S_ADD_B: state_d = S_WB;
      S_WB: begin
        if (add_done) begin
          c_d     = add_result[W-1:0];
          state_d = S_TM;
        end
      end
      // C odd: add M so the sum becomes even and the shift is exact.
      S_TM:    state_d = c_q[0] ? S_ADD_M : S_SHR;
      S_ADD_M: state_d = S_WM;
      S_WM: begin
        if (add_done) begin
          c_d     = add_result[W-1:0];
          state_d = S_SHR;
        end
      end
      S_SHR: begin
        c_d     = c_q >> 1;
        i_d     = i_q + IW'(1);
        state_d = (i_q == IW'(N - 1)) ? S_FS : S_TB;
      end
      S_FS: state_d = S_WS;
      S_WS: begin
        if (add_done) begin
          // No borrow out of C-M means C >= M: keep the difference.
          result_d = add_result[W] ? add_result[N-1:0] : c_q[N-1:0];
          state_d  = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      i_q      <= i_d;
      result_q <= result_d;
    end
  end

  // NOTE: operand latches carry no reset; they are always rewritten on an
  // accepted start before being used, so a reset would only cost area/routing.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    m_q <= m_d;
  end

  // Operand selection depends only on state, so the adder inputs stay stable
  // from add_start until add_done (C only changes on the add_done edge).
  assign op           = (state_q == S_FS || state_q == S_WS) ? OP_SUB : OP_ADD;
  assign add_subtract = op;
  assign add_start    = (state_q == S_ADD_B) || (state_q == S_ADD_M) || (state_q == S_FS);
  assign add_a        = c_q;
  assign add_b        = (state_q == S_ADD_B || state_q == S_WB) ? {{(W - N){1'b0}}, b_q}
                                                                 : {{(W - N){1'b0}}, m_q};
  assign result       = result_q;
  assign done         = (state_q == S_FIN);
  assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);

endmodule : mont_mul_ctrl

// File: tb/tb_mont_mul_ctrl.sv
// Self-checking bench for mont_mul_ctrl. Contains a behavioural model of the
// multi-precision adder (random 1-2 cycle latency), a handshake monitor and a
// result scoreboard fed by an independent reference: a*b mod M by
// double-and-add, followed by N modular halvings.
module tb_mont_mul_ctrl;
  import mont_mul_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [N-1:0] in_a, in_b, in_m;
  logic [N-1:0] result;
  logic         done, busy, add_start, add_subtract;
  logic [W-1:0] add_a, add_b;
  logic [W:0]   add_result;
  logic         add_done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int n_addp = 0;
  int n_subp = 0;

  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  mont_mul_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  // ---------------- adder model ----------------
  logic         mdl_busy;
  int unsigned  mdl_cnt;
  logic [W:0]   mdl_res;
  logic [W-1:0] cap_a, cap_b;
  logic         cap_sub;

  always @(posedge clk) begin
    if (!resetn) begin
      mdl_busy   <= 1'b0;
      mdl_cnt    <= 0;
      add_done   <= 1'b0;
      add_result <= '0;
    end else begin
      add_done <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          add_done   <= 1'b1;
          add_result <= mdl_res;
          mdl_busy   <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (add_start) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= $urandom_range(1, 0);
        cap_a    <= add_a;
        cap_b    <= add_b;
        cap_sub  <= add_subtract;
        mdl_res  <= add_subtract ? ({1'b0, add_a} + {1'b0, ~add_b} + 1'b1)
                                 : ({1'b0, add_a} + {1'b0, add_b});
      end
    end
  end

  // ---------------- monitors ----------------
  longint       cyc = 0;
  longint       last_done = -10;
  logic         stable_ok = 1'b1;
  logic         prev_done = 1'b0;
  logic         prev_busy = 1'b0;
  logic [N-1:0] exp_v;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      last_done = -10;
      prev_done = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (add_start) begin
        if (add_subtract) n_subp++; else n_addp++;
        n_vec++;
        if (add_done || (cyc - last_done) < 2 || mdl_busy) begin
          n_err++;
          $display("FAIL handshake_gap: cyc=%0d add_done=%0b since_done=%0d adder_busy=%0b required gap>=2 idle adder",
                   cyc, add_done, cyc - last_done, mdl_busy);
        end
        stable_ok = 1'b1;
      end else if (mdl_busy || add_done) begin
        if (add_a !== cap_a || add_b !== cap_b || add_subtract !== cap_sub) stable_ok = 1'b0;
      end
      if (add_done) begin
        n_vec++;
        if (!stable_ok) begin
          n_err++;
          $display("FAIL operand_stable: cyc=%0d operands changed between add_start and add_done, required stable", cyc);
        end
        last_done = cyc;
      end
      if (done) begin
        done_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_done: cyc=%0d done with no outstanding operation, result low=%h", cyc, result[63:0]);
        end else begin
          exp_v = exp_q.pop_front();
          if (result !== exp_v) begin
            n_err++;
            $display("FAIL result: cyc=%0d got low64=%h required low64=%h", cyc, result[63:0], exp_v[63:0]);
          end
        end
        n_vec++;
        if (busy !== 1'b0 || prev_done !== 1'b0 || prev_busy !== 1'b1) begin
          n_err++;
          $display("FAIL done_busy: busy=%0b prev_done=%0b prev_busy=%0b required 0/0/1", busy, prev_done, prev_busy);
        end
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] m);
    logic [N:0] r, mm, bb;
    mm = {1'b0, m};
    bb = {1'b0, b};
    r  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      r = r << 1;
      if (r >= mm) r = r - mm;
      if (a[j]) begin
        r = r + bb;
        if (r >= mm) r = r - mm;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (r[0]) r = r + mm;
      r = r >> 1;
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input logic [N-1:0] expv);
    @(negedge clk);
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    in_m  = m;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n0;
    bit seen;
    n0   = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (done_cnt > n0) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no done within 20000 cycles, required done", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (result !== '0)        begin n_err++; $display("FAIL reset_result: got %h required 0", result[63:0]); end
    n_vec++; if (done !== 1'b0)        begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_vec++; if (add_start !== 1'b0)   begin n_err++; $display("FAIL reset_add_start: got %b required 0", add_start); end
    n_vec++; if (add_subtract !== 1'b0) begin n_err++; $display("FAIL reset_add_subtract: got %b required 0", add_subtract); end
    resetn = 1'b1;
  endtask

  task automatic test_small_modulus();
    int n0;
    n0 = done_cnt;
    do_start(N'(1), N'(3), N'(13), N'(1));
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b required 1", busy); end
    wait_done("small_modulus");
    repeat (40) @(negedge clk);
    n_vec++;
    if (done_cnt - n0 != 1) begin n_err++; $display("FAIL small_modulus_done_count: got %0d required 1", done_cnt - n0); end
    n_vec++;
    if (result !== N'(1)) begin n_err++; $display("FAIL small_modulus_held: got %h required 1", result[63:0]); end
  endtask

  task automatic test_zero_a();
    n_addp = 0;
    n_subp = 0;
    do_start(N'(0), N'(7), N'(13), N'(0));
    wait_done("zero_a");
    n_vec++;
    if (n_addp != 0) begin n_err++; $display("FAIL zero_a_adds: got %0d add pulses required 0", n_addp); end
    n_vec++;
    if (n_subp != 1) begin n_err++; $display("FAIL zero_a_subs: got %0d subtract pulses required 1", n_subp); end
  endtask

  task automatic test_large_modulus();
    logic [N-1:0] m, a;
    m = '1;
    m = m - N'(158);
    a = m - N'(1);
    n_subp = 0;
    do_start(a, a, m, mont_ref(a, a, m));
    wait_done("large_modulus");
    n_vec++;
    if (n_subp != 1) begin n_err++; $display("FAIL large_modulus_subs: got %0d required 1", n_subp); end
  endtask

  task automatic test_random(input int count);
    logic [N-1:0] m, a, b;
    for (int t = 0; t < count; t++) begin
      m = rand_wide();
      m[0] = 1'b1;
      m[N-1] = 1'b1;
      a = rand_wide() % m;
      b = rand_wide() % m;
      do_start(a, b, m, mont_ref(a, b, m));
      wait_done("random");
    end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] m, a, b;
    bit seen;
    int n0;
    m = rand_wide();
    m[0] = 1'b1;
    m[N-1] = 1'b1;
    a = m - N'(1);
    b = rand_wide() % m;
    do_start(a, b, m, mont_ref(a, b, m));
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (add_start && !add_subtract) seen = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL reset_mid_op_no_add: no add_start within 50 cycles, required one"); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    exp_q.delete();
    n0 = done_cnt;
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
    n_vec++; if (result !== '0)   begin n_err++; $display("FAIL mid_reset_result: got %h required 0", result[63:0]); end
    n_vec++; if (add_start !== 1'b0) begin n_err++; $display("FAIL mid_reset_add_start: got %b required 0", add_start); end
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    n_vec++;
    if (done_cnt != n0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_idle: dones=%0d busy=%b required 0 dones and idle", done_cnt - n0, busy);
    end
    b = rand_wide() % m;
    do_start(a, b, m, mont_ref(a, b, m));
    wait_done("after_reset");
  endtask

  task automatic test_start_while_busy();
    logic [N-1:0] m, a, b;
    int n0;
    m = rand_wide();
    m[0] = 1'b1;
    m[N-1] = 1'b1;
    a = rand_wide() % m;
    b = rand_wide() % m;
    n0 = done_cnt;
    do_start(a, b, m, mont_ref(a, b, m));
    repeat (20) @(negedge clk);
    start = 1'b1;
    in_a  = rand_wide() % m;
    in_b  = rand_wide() % m;
    in_m  = N'(13);
    @(negedge clk);
    start = 1'b0;
    wait_done("start_while_busy");
    repeat (60) @(negedge clk);
    n_vec++;
    if (done_cnt - n0 != 1) begin n_err++; $display("FAIL start_while_busy_dones: got %0d required 1", done_cnt - n0); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_while_busy_idle: busy=%b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_small_modulus();
    test_zero_a();
    test_large_modulus();
    test_reset_mid_op();
    test_start_while_busy();
    test_random(3);
    repeat (5) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mont_mul_ctrl
